// File: rtl/fpu_sp_sub_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_sp_sub_arbiter
//   Shares one single-precision FPU subtract unit (A - BS) between NREQ
//   requesters. Round-robin grant, one operation in flight, valid/ready
//   handshakes on both the request and the response side.
//
//   Parameters
//     NREQ  number of requesters (2..8)
//     LAT   FPU latency in cycles from the first dval=1 edge to a valid Out
//
//   Ports
//     clk, rst            clock (rising edge), asynchronous active-high reset
//     req_valid/ready     per-requester request handshake (ready is one-hot)
//     req_a, req_b        operand pairs, requester i at [32*i +: 32]
//     rsp_valid/ready     per-requester response handshake (valid is one-hot)
//     rsp_data            captured FPU result (IEEE-754 single bit pattern)
//     fpu_a, fpu_bs       operands driven to the FPU, held for the operation
//     fpu_dval            FPU data-valid, high for every RUN cycle
//     fpu_out             FPU result
//     busy                an operation or response is outstanding
//
//   Optional build macro FPU_SUB_ARB_PERF_EN adds two saturating 16-bit
//   counters: perf_ops (completed response handshakes) and perf_stall
//   (response cycles where the granted requester was not ready).
// ---------------------------------------------------------------------------
module fpu_sp_sub_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [31:0]          fpu_a,
    output logic [31:0]          fpu_bs,
    output logic                 fpu_dval,
    input  logic [31:0]          fpu_out,
    output logic                 busy
`ifdef FPU_SUB_ARB_PERF_EN
    ,
    output logic [15:0]          perf_ops,
    output logic [15:0]          perf_stall
`endif
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [GW:0] NREQ_W = (GW + 1)'(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    fpu_a_q, fpu_a_d;
    logic [31:0]    fpu_bs_q, fpu_bs_d;
    logic [31:0]    rsp_data_q, rsp_data_d;
    logic [GW-1:0]  win, cand;
    logic           win_found;

    // (base + step) mod NREQ; step never exceeds NREQ, so one wrap suffices.
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input logic [GW:0] step);
        logic [GW:0] sum;
        sum = {1'b0, base} + step;
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        return sum[GW-1:0];
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win       = last_grant_q;
        cand      = last_grant_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = rr_idx(last_grant_q, (GW + 1)'(k));
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        fpu_a_d      = fpu_a_q;
        fpu_bs_d     = fpu_bs_q;
        rsp_data_d   = rsp_data_q;
        req_ready    = '0;
        rsp_valid    = '0;
        fpu_dval     = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is gated by rst so the accept port reads 0 while in reset.
                if (win_found && !rst) begin
                    req_ready[win] = 1'b1;
                    gnt_d          = win;
                    cnt_d          = CW'(LAT);
                    state_d        = RUN;
                    for (int i = 0; i < NREQ; i++) begin
                        if (win == GW'(i)) begin
                            fpu_a_d  = req_a[32*i +: 32];
                            fpu_bs_d = req_b[32*i +: 32];
                        end
                    end
                end
            end
            RUN: begin
                // LAT+1 cycles: the FPU result is valid in the cycle cnt reaches 0.
                fpu_dval = 1'b1;
                if (cnt_q == '0) begin
                    rsp_data_d = fpu_out;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    last_grant_d = gnt_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NREQ - 1);
            gnt_q        <= '0;
            cnt_q        <= '0;
            fpu_a_q      <= '0;
            fpu_bs_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            fpu_a_q      <= fpu_a_d;
            fpu_bs_q     <= fpu_bs_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign fpu_a    = fpu_a_q;
    assign fpu_bs   = fpu_bs_q;
    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != IDLE);

`ifdef FPU_SUB_ARB_PERF_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (state_q == RESP) begin
            if (rsp_ready[gnt_q]) perf_ops_d   = sat_inc(perf_ops_q);
            else                  perf_stall_d = sat_inc(perf_stall_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fpu_sp_sub_arbiter.sv
`timescale 1ns/1ps
module tb_fpu_sp_sub_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [127:0]  req_a = '0;
    logic [127:0]  req_b = '0;
    logic [3:0]    req_ready;
    logic [3:0]    rsp_valid;
    logic [3:0]    rsp_ready = '0;
    logic [31:0]   rsp_data;
    logic [31:0]   fpu_a;
    logic [31:0]   fpu_bs;
    logic          fpu_dval;
    logic [31:0]   fpu_out;
    logic          busy;
`ifdef FPU_SUB_ARB_PERF_EN
    logic [15:0]   perf_ops;
    logic [15:0]   perf_stall;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fpu_sp_sub_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .fpu_a(fpu_a), .fpu_bs(fpu_bs), .fpu_dval(fpu_dval), .fpu_out(fpu_out),
        .busy(busy)
`ifdef FPU_SUB_ARB_PERF_EN
        , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
    );

    // FPU stand-in: registered A-B for the directed operand pairs, 0 when dval is low.
    function automatic logic [31:0] sub_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40400000, 32'h3F800000}: return 32'h40000000; // 3 - 1 = 2
            {32'h3F800000, 32'h40000000}: return 32'hBF800000; // 1 - 2 = -1
            {32'h3FC00000, 32'h3FC00000}: return 32'h00000000; // 1.5 - 1.5 = 0
            {32'h40A00000, 32'h3F800000}: return 32'h40800000; // 5 - 1 = 4
            {32'h41200000, 32'h40000000}: return 32'h41000000; // 10 - 2 = 8
            default:                      return a ^ b;
        endcase
    endfunction

    always_ff @(posedge clk) fpu_out <= fpu_dval ? sub_model(fpu_a, fpu_bs) : 32'h0;

    // Drives one full operation for requester r; returns captured data, rsp_valid, latency.
    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input int stall,
                          output logic [31:0] data, output logic [3:0] vld, output int lat);
        int n;
        @(negedge clk);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_valid = 4'b0001 << r;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat  = n;
        data = rsp_data;
        vld  = rsp_valid;
        repeat (stall) @(negedge clk);
        rsp_ready = 4'b0001 << r;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        repeat (2) @(negedge clk);
        n_total++; if (req_ready !== 4'h0) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 4'h0) $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
        n_total++; if ({fpu_a, fpu_bs} !== 64'h0) $display("FAIL reset_fpu_ops: got %h %h want 0 0", fpu_a, fpu_bs); else n_pass++;
        n_total++; if ({fpu_dval, busy} !== 2'b00) $display("FAIL reset_dval_busy: got %b%b want 00", fpu_dval, busy); else n_pass++;
        req_valid = 4'hF;
        #1;
        n_total++; if (req_ready !== 4'h0) $display("FAIL reset_ready_held: got %b want 0000", req_ready); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL reset_first_winner: got %b want 0001", req_ready); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        req_a[31:0] = 32'h40400000; req_b[31:0] = 32'h3F800000; req_valid = 4'b0001;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL basic_accept: got %b want 0001", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        n_total++; if ({busy, fpu_dval} !== 2'b11) $display("FAIL basic_run1: busy/dval got %b%b want 11", busy, fpu_dval); else n_pass++;
        n_total++; if ({fpu_a, fpu_bs} !== {32'h40400000, 32'h3F800000}) $display("FAIL basic_fpu_ops: got %h %h want 40400000 3f800000", fpu_a, fpu_bs); else n_pass++;
        n_total++; if (req_ready !== 4'h0) $display("FAIL basic_ready_in_run: got %b want 0000", req_ready); else n_pass++;
        @(negedge clk);
        n_total++; if ({fpu_dval, rsp_valid} !== 5'b1_0000) $display("FAIL basic_run2: dval/rsp_valid got %b %b want 1 0000", fpu_dval, rsp_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (rsp_valid !== 4'b0001) $display("FAIL basic_rsp_valid: got %b want 0001", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 32'h40000000) $display("FAIL basic_rsp_data: got %h want 40000000", rsp_data); else n_pass++;
        n_total++; if (fpu_dval !== 1'b0) $display("FAIL basic_dval_resp: got %b want 0", fpu_dval); else n_pass++;
        rsp_ready = 4'b0001;
        @(negedge clk);
        n_total++; if ({busy, rsp_valid} !== 5'b0_0000) $display("FAIL basic_back_idle: busy/rsp_valid got %b %b want 0 0000", busy, rsp_valid); else n_pass++;
        n_total++; if (req_ready !== 4'b0010) $display("FAIL basic_next_grant: got %b want 0010", req_ready); else n_pass++;
        req_valid = '0; rsp_ready = '0;
    endtask

    task automatic test_req2();
        logic [31:0] d; logic [3:0] v; int lat;
        run_op(2, 32'h3F800000, 32'h40000000, 0, d, v, lat);
        n_total++; if (d !== 32'hBF800000) $display("FAIL req2_neg_data: got %h want bf800000", d); else n_pass++;
        n_total++; if (v !== 4'b0100) $display("FAIL req2_neg_valid: got %b want 0100", v); else n_pass++;
        n_total++; if (lat !== 2) $display("FAIL req2_latency: got %0d want 2", lat); else n_pass++;
        run_op(2, 32'h3FC00000, 32'h3FC00000, 0, d, v, lat);
        n_total++; if (d !== 32'h00000000) $display("FAIL req2_cancel_data: got %h want 00000000", d); else n_pass++;
        n_total++; if ({v, lat[3:0]} !== {4'b0100, 4'd2}) $display("FAIL req2_cancel_vld_lat: got %b %0d want 0100 2", v, lat); else n_pass++;
    endtask

    task automatic test_drop();
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        n_total++; if (req_ready !== 4'b1000) $display("FAIL drop_ready: got %b want 1000", req_ready); else n_pass++;
        #2 req_valid = '0;
        @(negedge clk);
        n_total++; if ({busy, req_ready} !== 5'b0_0000) $display("FAIL drop_no_accept: busy/ready got %b %b want 0 0000", busy, req_ready); else n_pass++;
    endtask

    task automatic test_stall();
        @(negedge clk);
        req_a[63:32] = 32'h40A00000; req_b[63:32] = 32'h3F800000; req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        req_valid = 4'b1101; rsp_ready = 4'b1101;
        #1;
        for (int i = 0; i < 10; i++) begin
            n_total++; if (rsp_valid !== 4'b0010) $display("FAIL stall_rsp_valid[%0d]: got %b want 0010", i, rsp_valid); else n_pass++;
            n_total++; if (rsp_data !== 32'h40800000) $display("FAIL stall_rsp_data[%0d]: got %h want 40800000", i, rsp_data); else n_pass++;
            n_total++; if ({req_ready, fpu_dval} !== 5'b0000_0) $display("FAIL stall_ready_dval[%0d]: got %b %b want 0000 0", i, req_ready, fpu_dval); else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        n_total++; if (req_ready !== 4'b0100) $display("FAIL stall_next_grant: got %b want 0100", req_ready); else n_pass++;
        req_valid = '0; rsp_ready = '0;
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        logic [31:0] exp_data [4] = '{32'h40000000, 32'h40800000, 32'h41000000, 32'hBF800000};
        int acc_cnt = 0;
        int last_cyc = 0;
        int dval_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_a = {32'h3F800000, 32'h41200000, 32'h40A00000, 32'h40400000};
        req_b = {32'h40000000, 32'h40000000, 32'h3F800000, 32'h3F800000};
        req_valid = 4'hF; rsp_ready = 4'hF;
        #1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (fpu_dval) dval_cnt++;
            if (rsp_valid != '0 && acc_cnt > 0) begin
                n_total++; if (rsp_valid !== (4'b0001 << exp_seq[acc_cnt-1])) $display("FAIL rr_rsp_valid[%0d]: got %b want %b", acc_cnt-1, rsp_valid, 4'b0001 << exp_seq[acc_cnt-1]); else n_pass++;
                n_total++; if (rsp_data !== exp_data[exp_seq[acc_cnt-1]]) $display("FAIL rr_rsp_data[%0d]: got %h want %h", acc_cnt-1, rsp_data, exp_data[exp_seq[acc_cnt-1]]); else n_pass++;
            end
            if (req_ready != '0 && acc_cnt < 5) begin
                n_total++; if (req_ready !== (4'b0001 << exp_seq[acc_cnt])) $display("FAIL rr_grant[%0d]: got %b want %b", acc_cnt, req_ready, 4'b0001 << exp_seq[acc_cnt]); else n_pass++;
                if (acc_cnt > 0) begin
                    n_total++; if (cyc - last_cyc !== 4) $display("FAIL rr_interval[%0d]: got %0d want 4", acc_cnt, cyc - last_cyc); else n_pass++;
                    n_total++; if (dval_cnt !== 2) $display("FAIL rr_dval_cycles[%0d]: got %0d want 2", acc_cnt, dval_cnt); else n_pass++;
                end
                dval_cnt = 0; last_cyc = cyc; acc_cnt++;
            end
            @(negedge clk);
            #1;
        end
        req_valid = '0; rsp_ready = '0;
        n_total++; if (acc_cnt !== 5) $display("FAIL rr_accept_count: got %0d want 5", acc_cnt); else n_pass++;
    endtask

    task automatic test_single();
        logic [31:0] d; logic [3:0] v; int lat;
        run_op(3, 32'h41200000, 32'h40000000, 0, d, v, lat);
        n_total++; if ({v, d} !== {4'b1000, 32'h41000000}) $display("FAIL single_op1: got %b %h want 1000 41000000", v, d); else n_pass++;
        run_op(3, 32'h40400000, 32'h3F800000, 0, d, v, lat);
        n_total++; if ({v, d} !== {4'b1000, 32'h40000000}) $display("FAIL single_op2: got %b %h want 1000 40000000", v, d); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d; logic [3:0] v; int lat;
        int seen;
        run_op(0, 32'h40A00000, 32'h3F800000, 0, d, v, lat);
        n_total++; if (d !== 32'h40800000) $display("FAIL midrst_pre_data: got %h want 40800000", d); else n_pass++;
        @(negedge clk);
        req_a[95:64] = 32'h40400000; req_b[95:64] = 32'h3F800000; req_valid = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        n_total++; if ({req_ready, rsp_valid, fpu_dval, busy} !== 10'h0) $display("FAIL midrst_ctrl: got %b %b %b %b want all 0", req_ready, rsp_valid, fpu_dval, busy); else n_pass++;
        n_total++; if ({rsp_data, fpu_a, fpu_bs} !== 96'h0) $display("FAIL midrst_data: got %h %h %h want 0", rsp_data, fpu_a, fpu_bs); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL midrst_no_rsp: got %0d active cycles want 0", seen); else n_pass++;
        req_valid = 4'b0101;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL midrst_next_grant: got %b want 0001", req_ready); else n_pass++;
        req_valid = '0;
    endtask

`ifdef FPU_SUB_ARB_PERF_EN
    task automatic test_perf();
        logic [31:0] d; logic [3:0] v; int lat;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if ({perf_ops, perf_stall} !== 32'h0) $display("FAIL perf_reset: got %h %h want 0 0", perf_ops, perf_stall); else n_pass++;
        run_op(0, 32'h40400000, 32'h3F800000, 0, d, v, lat);
        run_op(1, 32'h40A00000, 32'h3F800000, 10, d, v, lat);
        run_op(2, 32'h41200000, 32'h40000000, 0, d, v, lat);
        n_total++; if (perf_ops !== 16'd3) $display("FAIL perf_ops: got %0d want 3", perf_ops); else n_pass++;
        n_total++; if (perf_stall !== 16'd10) $display("FAIL perf_stall: got %0d want 10", perf_stall); else n_pass++;
        force dut.perf_ops_q = 16'hFFFF;
        @(negedge clk);
        release dut.perf_ops_q;
        run_op(3, 32'h40400000, 32'h3F800000, 0, d, v, lat);
        n_total++; if (perf_ops !== 16'hFFFF) $display("FAIL perf_ops_sat: got %h want ffff", perf_ops); else n_pass++;
        n_total++; if (perf_stall !== 16'd10) $display("FAIL perf_stall_hold: got %0d want 10", perf_stall); else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_req2();
        test_drop();
        test_stall();
        test_round_robin();
        test_single();
        test_reset_mid_run();
`ifdef FPU_SUB_ARB_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
